// File: rtl/layer_compositor_pkg.sv
// Shared types and constants for the layer compositor: RGB struct, reset-time
// default palette table and the transparent-index default.
package compositor_pkg;

    localparam int          KEY_IDX_DEFAULT = 0;
    localparam logic [23:0] MASK_RGB        = 24'hC832C8;
    localparam int          DEF_DEPTH       = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t DEF_PALETTE [DEF_DEPTH] = '{
        24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
        24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
        24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
        24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
    };

    // Palette p is the base table tinted by p*0x20 in every channel so palettes differ.
    function automatic rgb_t default_color(input int pal, input int idx);
        logic [7:0] tint;
        tint = 8'(pal << 5);
        return DEF_PALETTE[4'(idx)] ^ {tint, tint, tint};
    endfunction

endpackage

// File: rtl/layer_compositor_priority_enc.sv
// First-opaque priority encoder: lowest set request wins; NUM_REQ when none set.
module layer_priority_enc #(
    parameter int NUM_REQ = 12,
    parameter int ID_W    = $clog2(NUM_REQ + 1)
) (
    input  logic [NUM_REQ-1:0] req,
    output logic [ID_W-1:0]    win_id,
    output logic               hit_any
);

    always_comb begin
        win_id  = ID_W'(NUM_REQ);
        hit_any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_id  = ID_W'(i);
                hit_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage sprite layer compositor with run-time palettes and registered VGA output.
// Optional fade-to-black enabled by defining COMPOSITOR_FADE_EN.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int NUM_LAYERS   = 12,
    parameter int IDX_W        = 4,
    parameter int NUM_PALETTES = 4,
    parameter int KEY_IDX      = KEY_IDX_DEFAULT,
    parameter int COLOR_W      = 24,
    localparam int PSEL_W      = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1,
    localparam int TL_W        = $clog2(NUM_LAYERS + 1)
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         pix_valid_in,
    input  logic                         blank_in,
    input  logic [NUM_LAYERS-1:0]        layer_hit,
    input  logic [NUM_LAYERS*IDX_W-1:0]  layer_idx,
    input  logic [NUM_LAYERS*PSEL_W-1:0] layer_pal,
    input  logic [IDX_W-1:0]             bg_idx,
    input  logic                         pal_we,
    input  logic [PSEL_W-1:0]            pal_sel,
    input  logic [IDX_W-1:0]             pal_addr,
    input  logic [COLOR_W-1:0]           pal_wdata,
    input  logic                         frame_tick,
    input  logic                         fade_start,
    output logic [7:0]                   VGA_R,
    output logic [7:0]                   VGA_G,
    output logic [7:0]                   VGA_B,
    output logic                         pix_valid_out,
    output logic                         blank_out,
    output logic [TL_W-1:0]              top_layer,
    output logic                         fade_busy
);

    localparam int                DEPTH  = 1 << IDX_W;
    localparam int                STAGES = 2;
    localparam logic [IDX_W-1:0]  KEY    = IDX_W'(KEY_IDX);
    localparam logic [PSEL_W:0]   NPAL   = (PSEL_W + 1)'(NUM_PALETTES);

    logic [NUM_PALETTES-1:0][DEPTH-1:0][COLOR_W-1:0] pal_mem;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int p = 0; p < NUM_PALETTES; p++)
                for (int i = 0; i < DEPTH; i++)
                    pal_mem[p][i] <= default_color(p, i);
        end else if (pal_we && ({1'b0, pal_sel} < NPAL)) begin
            pal_mem[pal_sel][pal_addr] <= pal_wdata;
        end
    end

    // Per-layer lookup; reads see pre-write contents, giving read-before-write.
    logic [NUM_LAYERS-1:0][COLOR_W-1:0] lane_color, s1_color;
    logic [NUM_LAYERS-1:0]              lane_opaque, s1_opaque;
    logic [COLOR_W-1:0]                 s1_bg;
    logic [STAGES:1]                    vld_pipe, blank_pipe;

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_lane
        logic [IDX_W-1:0]  idx;
        logic [PSEL_W-1:0] psel;
        assign idx            = layer_idx[i*IDX_W +: IDX_W];
        assign psel           = layer_pal[i*PSEL_W +: PSEL_W];
        assign lane_color[i]  = ({1'b0, psel} < NPAL) ? pal_mem[psel][idx] : pal_mem[0][idx];
        assign lane_opaque[i] = layer_hit[i] && (idx != KEY);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_color   <= '0;
            s1_opaque  <= '0;
            s1_bg      <= '0;
            vld_pipe   <= '0;
            blank_pipe <= '0;
        end else begin
            s1_color   <= lane_color;
            s1_opaque  <= lane_opaque;
            s1_bg      <= pal_mem[0][bg_idx];
            vld_pipe   <= {vld_pipe[STAGES-1:1], pix_valid_in};
            blank_pipe <= {blank_pipe[STAGES-1:1], blank_in};
        end
    end

    logic [TL_W-1:0]    win_id;
    logic               hit_any;
    logic [COLOR_W-1:0] win_color;
    rgb_t               wc;

    layer_priority_enc #(.NUM_REQ(NUM_LAYERS), .ID_W(TL_W)) u_enc (
        .req     (s1_opaque),
        .win_id  (win_id),
        .hit_any (hit_any)
    );

    always_comb begin
        win_color = s1_bg;
        for (int i = 0; i < NUM_LAYERS; i++)
            if (hit_any && win_id == TL_W'(i)) win_color = s1_color[i];
    end
    assign wc = win_color;

    logic [3:0] gain;

`ifdef COMPOSITOR_FADE_EN
    logic [2:0] level;
    logic       busy_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            level  <= '0;
            busy_q <= 1'b0;
        end else if (fade_start) begin
            level  <= '0;
            busy_q <= 1'b1;
        end else if (frame_tick && busy_q) begin
            if (level == 3'd7) busy_q <= 1'b0;
            else               level  <= level + 3'd1;
        end
    end

    assign gain      = 4'd8 - {1'b0, level};
    assign fade_busy = busy_q;
`else
    logic unused_fade;
    assign unused_fade = &{1'b0, frame_tick, fade_start};
    assign gain        = 4'd8;
    assign fade_busy   = 1'b0;
`endif

    // gain of 8 is unity, so the no-fade build reduces to a plain register.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [3:0] g);
        logic [11:0] prod;
        prod = {4'b0, c} * {8'b0, g};
        return 8'(prod >> 3);
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
            top_layer <= TL_W'(NUM_LAYERS);
        end else begin
            VGA_R     <= blank_pipe[1] ? 8'h00 : scale(wc.r, gain);
            VGA_G     <= blank_pipe[1] ? 8'h00 : scale(wc.g, gain);
            VGA_B     <= blank_pipe[1] ? 8'h00 : scale(wc.b, gain);
            top_layer <= win_id;
        end
    end

    assign pix_valid_out = vld_pipe[STAGES];
    assign blank_out     = blank_pipe[STAGES];

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed scenarios plus a randomized stream vs. a palette model.
module tb_layer_compositor;
    import compositor_pkg::*;

    localparam int NL = 12, IW = 4, NP = 4, PW = 2, TW = 4;

    logic            Clk = 1'b0, Reset = 1'b1;
    logic            pix_valid_in, blank_in, pal_we, frame_tick, fade_start;
    logic [NL-1:0]   layer_hit;
    logic [NL*IW-1:0] layer_idx;
    logic [NL*PW-1:0] layer_pal;
    logic [IW-1:0]   bg_idx, pal_addr;
    logic [PW-1:0]   pal_sel;
    logic [23:0]     pal_wdata;
    logic [7:0]      VGA_R, VGA_G, VGA_B;
    logic            pix_valid_out, blank_out, fade_busy;
    logic [TW-1:0]   top_layer;

    layer_compositor #(.NUM_LAYERS(NL), .IDX_W(IW), .NUM_PALETTES(NP), .KEY_IDX(0), .COLOR_W(24)) dut (
        .Clk(Clk), .Reset(Reset), .pix_valid_in(pix_valid_in), .blank_in(blank_in),
        .layer_hit(layer_hit), .layer_idx(layer_idx), .layer_pal(layer_pal), .bg_idx(bg_idx),
        .pal_we(pal_we), .pal_sel(pal_sel), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .frame_tick(frame_tick), .fade_start(fade_start),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .pix_valid_out(pix_valid_out),
        .blank_out(blank_out), .top_layer(top_layer), .fade_busy(fade_busy)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [23:0]   rgb;
        logic [TW-1:0] top;
        logic          vld;
        logic          blk;
    } exp_t;

    int          checks = 0, failures = 0;
    logic [23:0] model [NP][16];
    exp_t        expq [$];
    exp_t        obs;

    assign obs = {VGA_R, VGA_G, VGA_B, top_layer, pix_valid_out, blank_out};

    task automatic model_init();
        for (int p = 0; p < NP; p++)
            for (int i = 0; i < 16; i++)
                model[p][i] = default_color(p, i);
    endtask

    // Composited result of the pixel currently on the inputs, from the model palettes.
    function automatic exp_t ref_now();
        exp_t e;
        e.rgb = model[0][bg_idx];
        e.top = TW'(NL);
        for (int i = 0; i < NL; i++) begin
            if (layer_hit[i] && layer_idx[i*IW +: IW] != 4'd0) begin
                e.rgb = model[layer_pal[i*PW +: PW]][layer_idx[i*IW +: IW]];
                e.top = TW'(i);
                break;
            end
        end
        if (blank_in) e.rgb = 24'h0;
        e.vld = pix_valid_in;
        e.blk = blank_in;
        return e;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        layer_hit = '0; layer_idx = '0; layer_pal = '0; bg_idx = '0;
        pix_valid_in = 1'b0; blank_in = 1'b0; pal_we = 1'b0; pal_sel = '0;
        pal_addr = '0; pal_wdata = '0; frame_tick = 1'b0; fade_start = 1'b0;
    endtask

    task automatic set_layer(input int i, input logic hit, input logic [3:0] idx, input logic [1:0] pal);
        layer_hit[i]          = hit;
        layer_idx[i*IW +: IW] = idx;
        layer_pal[i*PW +: PW] = pal;
    endtask

    task automatic test_reset();
        exp_t e;
        idle();
        Reset = 1'b1; pix_valid_in = 1'b1; blank_in = 1'b1; layer_hit = '1;
        repeat (3) step();
        e = '{rgb: 24'h0, top: TW'(NL), vld: 1'b0, blk: 1'b0};
        checks++;
        if (obs !== e) begin failures++; $display("FAIL reset_outputs got=%h want=%h", obs, e); end
        checks++;
        if (fade_busy !== 1'b0) begin failures++; $display("FAIL reset_fade_busy got=%b want=0", fade_busy); end
        Reset = 1'b0;
        idle();
        model_init();
        repeat (2) step();
    endtask

    task automatic test_priority();
        exp_t e;
        idle(); pix_valid_in = 1'b1;
        set_layer(0, 1'b1, 4'd5, 2'd0);
        set_layer(3, 1'b1, 4'd7, 2'd0);
        step(); step();
        e = '{rgb: default_color(0, 5), top: 4'd0, vld: 1'b1, blk: 1'b0};
        checks++;
        if (obs !== e) begin failures++; $display("FAIL priority_l0_over_l3 got=%h want=%h", obs, e); end
    endtask

    task automatic test_key_and_bg();
        exp_t ea, eb, ec;
        idle(); pix_valid_in = 1'b1;
        set_layer(0, 1'b1, 4'd0, 2'd0);
        set_layer(3, 1'b1, 4'd7, 2'd0);
        ea = '{rgb: default_color(0, 7), top: 4'd3, vld: 1'b1, blk: 1'b0};
        step();
        idle(); pix_valid_in = 1'b1; bg_idx = 4'd9;
        set_layer(6, 1'b0, 4'd3, 2'd2);
        eb = '{rgb: default_color(0, 9), top: TW'(NL), vld: 1'b1, blk: 1'b0};
        step();
        checks++;
        if (obs !== ea) begin failures++; $display("FAIL key_transparent got=%h want=%h", obs, ea); end
        idle(); pix_valid_in = 1'b1;
        set_layer(11, 1'b1, 4'd15, 2'd3);
        ec = '{rgb: default_color(3, 15), top: 4'd11, vld: 1'b1, blk: 1'b0};
        step();
        checks++;
        if (obs !== eb) begin failures++; $display("FAIL background got=%h want=%h", obs, eb); end
        idle();
        step();
        checks++;
        if (obs !== ec) begin failures++; $display("FAIL last_layer_pal3 got=%h want=%h", obs, ec); end
    endtask

    task automatic test_pal_write();
        exp_t e;
        idle(); pix_valid_in = 1'b1;
        set_layer(1, 1'b1, 4'd4, 2'd2);
        pal_we = 1'b1; pal_sel = 2'd2; pal_addr = 4'd4; pal_wdata = 24'h123456;
        step();
        pal_we = 1'b0;
        step();
        e = '{rgb: default_color(2, 4), top: 4'd1, vld: 1'b1, blk: 1'b0};
        checks++;
        if (obs !== e) begin failures++; $display("FAIL pal_read_before_write got=%h want=%h", obs, e); end
        step();
        e = '{rgb: 24'h123456, top: 4'd1, vld: 1'b1, blk: 1'b0};
        checks++;
        if (obs !== e) begin failures++; $display("FAIL pal_write_visible got=%h want=%h", obs, e); end
        model[2][4] = 24'h123456;
    endtask

    task automatic test_blank_valid();
        exp_t ea, eb;
        idle(); pix_valid_in = 1'b1; blank_in = 1'b1;
        set_layer(0, 1'b1, 4'd5, 2'd0);
        ea = '{rgb: 24'h0, top: 4'd0, vld: 1'b1, blk: 1'b1};
        step();
        pix_valid_in = 1'b0; blank_in = 1'b0;
        eb = '{rgb: default_color(0, 5), top: 4'd0, vld: 1'b0, blk: 1'b0};
        step();
        checks++;
        if (obs !== ea) begin failures++; $display("FAIL blank_forces_black got=%h want=%h", obs, ea); end
        idle();
        step();
        checks++;
        if (obs !== eb) begin failures++; $display("FAIL invalid_passes_data got=%h want=%h", obs, eb); end
    endtask

    task automatic test_reset_mid();
        exp_t ez, ep;
        idle(); pix_valid_in = 1'b1;
        set_layer(2, 1'b1, 4'd9, 2'd1);
        step(); step();
        Reset = 1'b1;
        step();
        ez = '{rgb: 24'h0, top: TW'(NL), vld: 1'b0, blk: 1'b0};
        checks++;
        if (obs !== ez) begin failures++; $display("FAIL reset_mid_flush got=%h want=%h", obs, ez); end
        Reset = 1'b0;
        model_init();
        step();
        checks++;
        if (obs !== ez) begin failures++; $display("FAIL reset_release_zero got=%h want=%h", obs, ez); end
        step();
        ep = '{rgb: default_color(1, 9), top: 4'd2, vld: 1'b1, blk: 1'b0};
        checks++;
        if (obs !== ep) begin failures++; $display("FAIL after_reset_pixel got=%h want=%h", obs, ep); end
        idle();
    endtask

    task automatic test_back_to_back();
        exp_t e, w;
        idle();
        expq.delete();
        for (int k = 0; k <= 1000; k++) begin
            if (k < 1000) begin
                layer_hit    = NL'($urandom) & NL'($urandom);
                layer_idx    = (NL*IW)'({$urandom, $urandom});
                layer_pal    = (NL*PW)'($urandom);
                bg_idx       = IW'($urandom);
                pix_valid_in = ($urandom_range(0, 9) != 0);
                blank_in     = ($urandom_range(0, 9) == 0);
                pal_we       = ($urandom_range(0, 19) == 0);
                pal_sel      = PW'($urandom);
                pal_addr     = IW'($urandom);
                pal_wdata    = 24'($urandom);
            end else begin
                idle();
            end
            expq.push_back(ref_now());
            if (pal_we) model[pal_sel][pal_addr] = pal_wdata;
            step();
            if (expq.size() >= 2) begin
                w = expq.pop_front();
                checks++;
                if (obs !== w) begin
                    failures++;
                    $display("FAIL stream_pixel k=%0d got=%h want=%h", k - 1, obs, w);
                end
            end
        end
        e = expq.pop_front();
        if (e.vld !== 1'b0) $display("note: trailing entry unexpected");
        idle();
    endtask

`ifdef COMPOSITOR_FADE_EN
    task automatic tick();
        frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    endtask

    task automatic test_fade();
        idle();
        pal_we = 1'b1; pal_sel = 2'd0; pal_addr = 4'd1; pal_wdata = 24'hFFFFFF;
        step();
        idle(); pix_valid_in = 1'b1; bg_idx = 4'd1;
        fade_start = 1'b1; step(); fade_start = 1'b0;
        checks++;
        if (fade_busy !== 1'b1) begin failures++; $display("FAIL fade_busy_set got=%b want=1", fade_busy); end
        repeat (4) tick();
        step(); step();
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 24'h7F7F7F) begin failures++; $display("FAIL fade_level4 got=%h want=7f7f7f", {VGA_R, VGA_G, VGA_B}); end
        repeat (4) tick();
        checks++;
        if (fade_busy !== 1'b0) begin failures++; $display("FAIL fade_busy_clear got=%b want=0", fade_busy); end
        step(); step();
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 24'h1F1F1F) begin failures++; $display("FAIL fade_level7_hold got=%h want=1f1f1f", {VGA_R, VGA_G, VGA_B}); end
        fade_start = 1'b1; frame_tick = 1'b1; step(); fade_start = 1'b0; frame_tick = 1'b0;
        tick(); tick();
        fade_start = 1'b1; step(); fade_start = 1'b0;
        step(); step();
        checks++;
        if ({VGA_R, VGA_G, VGA_B, fade_busy} !== {24'hFFFFFF, 1'b1}) begin
            failures++; $display("FAIL fade_restart got=%h want=ffffff1", {VGA_R, VGA_G, VGA_B, fade_busy});
        end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_priority();
        test_key_and_bg();
        test_pal_write();
        test_blank_valid();
        test_reset_mid();
        test_back_to_back();
`ifdef COMPOSITOR_FADE_EN
        test_fade();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
